// File: rtl/pair_packer_pkg.sv
// rtl/pair_packer_pkg.sv - shared types and default sizing for the pair burst packer
// Holds the packer FSM state enum, the packed-word type and the default
// pointer/level widths derived from the default FIFO depth.
package pair_packer_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_BURST_LEN = 16;
  localparam int PTR_W         = $clog2(DEF_DEPTH);
  localparam int LVL_W         = PTR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } packer_state_t;

  typedef logic [2*DEF_WIDTH-1:0] packed_word_t;

endpackage

// File: rtl/pair_fifo_mem.sv
// rtl/pair_fifo_mem.sv - single write port, asynchronous read port word RAM
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write word
//   raddr  in   read address
//   rdata  out  word at raddr, combinational (no read latency)
// Contents are not reset; unwritten locations read as whatever they hold.
module pair_fifo_mem
  import pair_packer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pair_burst_packer.sv
// rtl/pair_burst_packer.sv - packs lane pairs into words and releases fixed-length bursts
// Optional build macro: PAIR_PACKER_DROP_CNT_EN adds a saturating drop counter port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          one-cycle pulse: lane pair complete
//   in_lane0/1        even / odd sample
//   out_data          {lane1, lane0} at FIFO head
//   out_valid/ready   output beat handshake
//   out_sop/out_eop   first / last beat of a burst, qualified by out_valid
//   level             words currently buffered
//   overflow          sticky: a pair was dropped since reset
//   drop_cnt          (macro only) count of dropped pairs, saturating
module pair_burst_packer
  import pair_packer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_lane0,
  input  logic [WIDTH-1:0]       in_lane1,
  output logic [2*WIDTH-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef PAIR_PACKER_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam int CNT_BITS = $clog2(BURST_LEN);

  localparam logic [LVL_BITS-1:0] FULL_LVL  = LVL_BITS'(DEPTH);
  localparam logic [LVL_BITS-1:0] BURST_LVL = LVL_BITS'(BURST_LEN);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);

  packer_state_t       state, state_nxt;
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] beat_cnt;
  logic                full, wr_en, drop, beat;

  // Full comes from the registered level, so a beat leaving this cycle
  // does not make room for a write arriving in the same cycle.
  assign full  = (level == FULL_LVL);
  assign wr_en = in_valid & ~full;
  assign drop  = in_valid & full;
  assign beat  = out_valid & out_ready;

  pair_fifo_mem #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({in_lane1, in_lane0}),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (beat)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !beat)      level <= level + 1'b1;
      else if (!wr_en && beat) level <= level - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= out_eop ? '0 : beat_cnt + 1'b1;
    end
  end

`ifdef PAIR_PACKER_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A burst only starts once a whole burst is buffered, so it never starves.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (level >= BURST_LVL) state_nxt = BURST;
      BURST:   if (beat && out_eop)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == BURST);
    out_sop   = (state == BURST) && (beat_cnt == '0);
    out_eop   = (state == BURST) && (beat_cnt == LAST_BEAT);
  end

endmodule

// File: tb/tb_pair_burst_packer.sv
// tb/tb_pair_burst_packer.sv - randomized scoreboard bench for pair_burst_packer
module tb_pair_burst_packer;

  localparam int DEPTH = 64;
  localparam int BL    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_lane0 = '0;
  logic [15:0] in_lane1 = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sop;
  logic        out_eop;
  logic [6:0]  level;
  logic        overflow;
`ifdef PAIR_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  pair_burst_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_lane0  (in_lane0),
    .in_lane1  (in_lane1),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .level     (level),
    .overflow  (overflow)
`ifdef PAIR_PACKER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words plus a burst position.
  logic [31:0] exp_q[$];
  int          mlevel = 0;
  int          beat_idx = 0;
  int          mdrop = 0;
  bit          movf = 1'b0;
  bit          prev_eop = 1'b0;
  bit          prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_sop", out_sop, 0);
      chk("rst_eop", out_eop, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
`ifdef PAIR_PACKER_DROP_CNT_EN
      chk("rst_drop_cnt", drop_cnt, 0);
`endif
      exp_q.delete();
      mlevel = 0; beat_idx = 0; mdrop = 0;
      movf = 0; prev_eop = 0; prev_valid = 0;
    end else begin
      logic [31:0] ew;
      bit wr, rd, dr;
      chk("level", level, mlevel);
      chk("overflow", overflow, movf);
`ifdef PAIR_PACKER_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, (mdrop > 65535) ? 65535 : mdrop);
`endif
      if (prev_eop) chk("eop_gap_idle", out_valid, 0);
      if (out_valid) begin
        ew = (exp_q.size() != 0) ? exp_q[0] : 'x;
        chk("data", out_data, ew);
        chk("sop", out_sop, beat_idx == 0);
        chk("eop", out_eop, beat_idx == BL - 1);
        if (!prev_valid) chk("burst_start_full", level >= BL, 1);
      end
      wr = in_valid && (mlevel < DEPTH);
      dr = in_valid && (mlevel >= DEPTH);
      rd = out_valid && out_ready && (exp_q.size() != 0);
      if (wr) exp_q.push_back({in_lane1, in_lane0});
      prev_eop = 0;
      if (rd) begin
        void'(exp_q.pop_front());
        prev_eop = (beat_idx == BL - 1);
        beat_idx = (beat_idx + 1) % BL;
      end
      mlevel = mlevel + (wr ? 1 : 0) - (rd ? 1 : 0);
      if (dr) begin movf = 1; mdrop++; end
      prev_valid = out_valid;
    end
  end

  // Ready driver: 0 manual, 1 pattern 1,0,0,1, 2 random.
  int rmode = 0;
  bit man_ready = 1'b1;
  int rpat = 0;
  always @(posedge clk) begin
    #2;
    case (rmode)
      1: begin out_ready = (rpat % 4 == 0) || (rpat % 4 == 3); rpat++; end
      2: out_ready = ($urandom % 4) != 0;
      default: out_ready = man_ready;
    endcase
  end

  task automatic send_pair(input logic [15:0] l0, input logic [15:0] l1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_lane0 = l0; in_lane1 = l1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk); #1;
      if (!out_valid && mlevel < BL) done = 1;
      n++;
    end
    chk({name, "_drain_timeout"}, done, 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({name, "_valid_timeout"}, out_valid, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rmode = 0; man_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic burst with the counting pattern.
    for (int k = 0; k < 16; k++) send_pair(16'(2*k), 16'(2*k+1));
    drain("basic");
    chk("basic_level_end", level, 0);

    // Sub-threshold and start latency.
    for (int k = 0; k < 15; k++) send_pair(16'($urandom), 16'($urandom));
    repeat (4) @(posedge clk); #1;
    chk("sub_valid", out_valid, 0);
    chk("sub_level", level, 15);
    @(posedge clk); #1;
    in_valid = 1'b1; in_lane0 = 16'h1234; in_lane1 = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_n1_valid", out_valid, 0);
    chk("lat_n1_level", level, 16);
    @(posedge clk); #1;
    chk("lat_n2_valid", out_valid, 1);
    drain("sub");

    // Backpressure 1,0,0,1.
    rmode = 1;
    for (int k = 0; k < 16; k++) send_pair(16'($urandom), 16'($urandom));
    drain("bp");
    rmode = 0;

    // Overflow and wrap.
    man_ready = 0;
    for (int k = 0; k < 70; k++) send_pair(16'(2*k), 16'(2*k+1));
    repeat (3) @(posedge clk); #1;
    chk("ovf_level", level, 64);
    chk("ovf_flag", overflow, 1);
`ifdef PAIR_PACKER_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt, 6);
`endif
    man_ready = 1;
    drain("ovf");

    // Full with a simultaneous beat: the write is dropped.
    man_ready = 0;
    for (int k = 0; k < 64; k++) send_pair(16'($urandom), 16'($urandom));
    wait_valid("full");
    chk("full_pre_level", level, 64);
    @(posedge clk); #1;
    in_valid = 1'b1; in_lane0 = 16'hDEAD; in_lane1 = 16'hBEEF; man_ready = 1;
    @(posedge clk); #1;
    in_valid = 1'b0; man_ready = 0;
    chk("full_rd_level", level, 63);
    man_ready = 1;
    drain("full");

    // Reset mid-burst after beat 5.
    for (int k = 0; k < 16; k++) send_pair(16'($urandom), 16'($urandom));
    begin
      int n = 0;
      while (beat_idx != 5 && n < 200) begin @(negedge clk); n++; end
      chk("midrst_reach_beat5", beat_idx, 5);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) send_pair(16'($urandom), 16'($urandom));
    wait_valid("postrst");
    chk("postrst_sop", out_sop, 1);
    drain("postrst");

    // Random traffic with random backpressure.
    rmode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 3 != 0) send_pair(16'($urandom), 16'($urandom));
      else @(posedge clk);
    end
    rmode = 0; man_ready = 1;
    drain("rand");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
